// File: rtl/vga_system_ram_dual.sv
// vga_system_ram_dual
// ---------------------------------------------------------------------------
// Two-port word RAM on one clock, with byte enables, an optional power-on
// clear sweep and pipelined reads.
//
// Parameters
//   DATA_WIDTH     : word width in bits (a multiple of 8)
//   ADDR_WIDTH     : word address width; DEPTH = 2**ADDR_WIDTH
//   CLEAR_ON_RESET : 1 = zero every word after reset, 0 = skip the sweep
//
// Optional feature macro
//   VGA_RAM_OUTREG_EN : adds an output register stage (read latency 2
//                       instead of 1, with valid delayed to match)
//
// Ports
//   clk, reset          : single clock, synchronous active-high reset
//   reset_req           : blocks new accepts on both ports while high
//   clken               : global clock enable; low freezes all state
//   freeze              : suppresses memory writes (writes still accepted)
//   s1_* / s2_*         : two identical slave ports (address, byteenable,
//                         chipselect, read, write, writedata, readdata,
//                         readdatavalid, waitrequest)
//   debug_state         : current FSM state (1 = CLEAR, 0 = READY)
//
// Handshake: a port transaction is accepted on a rising edge where
// chipselect=1, (read|write)=1 and waitrequest=0. read and write together
// count as a write. Each accepted read yields exactly one readdatavalid
// pulse a fixed number of enabled cycles later; readdata holds its last
// value while readdatavalid is low.
// ---------------------------------------------------------------------------
module vga_system_ram_dual #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 13,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_req,
  input  logic                    clken,
  input  logic                    freeze,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest,
  output logic                    debug_state
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    READY = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic busy;
  logic clear_we;
  logic s1_acc, s1_we, s1_re;
  logic s2_acc, s2_we, s2_re;

  assign debug_state = state;

  // waitrequest is deliberately combinational so that dropping clken or
  // raising reset_req stalls the masters in the same cycle.
  assign busy           = (state == CLEAR) || reset_req || !clken;
  assign s1_waitrequest = busy;
  assign s2_waitrequest = busy;

  assign s1_acc = s1_chipselect && (s1_read || s1_write) && !busy && !reset;
  assign s2_acc = s2_chipselect && (s2_read || s2_write) && !busy && !reset;
  // A write is still accepted under freeze; only the array update is dropped.
  assign s1_we  = s1_acc && s1_write && !freeze;
  assign s2_we  = s2_acc && s2_write && !freeze;
  assign s1_re  = s1_acc && !s1_write;
  assign s2_re  = s2_acc && !s2_write;

  assign clear_we = clken && !reset && (state == CLEAR);

  // Control FSM: CLEAR sweeps clr_cnt over every word, one per enabled cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_cnt <= '0;
    end else if (clk_en_clear()) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == {ADDR_WIDTH{1'b1}}) begin
        state <= READY;
      end
    end
  end

  function automatic logic clk_en_clear();
    return clken && (state == CLEAR);
  endfunction

  // Memory array. No reset: only the CLEAR sweep zeroes it. s1 bytes are
  // assigned after s2 bytes so s1 wins per byte on a same-address collision,
  // while s2 bytes that s1 leaves disabled still land.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[clr_cnt] <= '0;
    end
    for (int b = 0; b < BE_W; b++) begin
      if (s2_we && s2_byteenable[b]) begin
        mem[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
      end
      if (s1_we && s1_byteenable[b]) begin
        mem[s1_address][b*8 +: 8] <= s1_writedata[b*8 +: 8];
      end
    end
  end

  // Read pipeline. Reading the array in the same edge as a write returns
  // the pre-write word, which gives old-data read-during-write on both the
  // same port and the other port.
`ifdef VGA_RAM_OUTREG_EN
  logic                  s1_p_valid, s2_p_valid;
  logic [DATA_WIDTH-1:0] s1_p_data,  s2_p_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_p_valid       <= 1'b0;
      s2_p_valid       <= 1'b0;
      s1_p_data        <= '0;
      s2_p_data        <= '0;
      s1_readdatavalid <= 1'b0;
      s2_readdatavalid <= 1'b0;
      s1_readdata      <= '0;
      s2_readdata      <= '0;
    end else if (clken) begin
      s1_p_valid       <= s1_re;
      s2_p_valid       <= s2_re;
      if (s1_re) s1_p_data <= mem[s1_address];
      if (s2_re) s2_p_data <= mem[s2_address];
      s1_readdatavalid <= s1_p_valid;
      s2_readdatavalid <= s2_p_valid;
      if (s1_p_valid) s1_readdata <= s1_p_data;
      if (s2_p_valid) s2_readdata <= s2_p_data;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_readdatavalid <= 1'b0;
      s2_readdatavalid <= 1'b0;
      s1_readdata      <= '0;
      s2_readdata      <= '0;
    end else if (clken) begin
      s1_readdatavalid <= s1_re;
      s2_readdatavalid <= s2_re;
      if (s1_re) s1_readdata <= mem[s1_address];
      if (s2_re) s2_readdata <= mem[s2_address];
    end
  end
`endif

endmodule

// File: tb/tb_vga_system_ram_dual.sv
// tb_vga_system_ram_dual
// Bench for vga_system_ram_dual (ADDR_WIDTH=4, DATA_WIDTH=32). A driver
// applies directed and random cycles and updates a word-array reference
// model; expected read data and arrival times go into per-port queues that
// a separate monitor pops whenever the DUT presents readdatavalid.
module tb_vga_system_ram_dual;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int BW    = DW / 8;
`ifdef VGA_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, reset_req, clken, freeze;
  logic [AW-1:0] s1_address, s2_address;
  logic [BW-1:0] s1_byteenable, s2_byteenable;
  logic          s1_chipselect, s1_read, s1_write;
  logic          s2_chipselect, s2_read, s2_write;
  logic [DW-1:0] s1_writedata, s2_writedata;
  logic [DW-1:0] s1_readdata, s2_readdata;
  logic          s1_readdatavalid, s2_readdatavalid;
  logic          s1_waitrequest, s2_waitrequest;
  logic          debug_state;

  vga_system_ram_dual #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .freeze(freeze),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable),
    .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
    .s1_writedata(s1_writedata), .s1_readdata(s1_readdata),
    .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable),
    .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
    .s2_writedata(s2_writedata), .s2_readdata(s2_readdata),
    .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest),
    .debug_state(debug_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp1_q[$], exp2_q[$];
  int            t1_q[$], t2_q[$];
  int            clear_left = 0;
  int            ecyc = 0;
  bit            rst_done = 0;
  logic [DW-1:0] last1 = '0, last2 = '0;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
      input logic [DW-1:0] wd, input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    reset = 0; reset_req = 0; clken = 1; freeze = 0;
    s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = '0;
    s1_byteenable = '0; s1_writedata = '0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = '0;
    s2_byteenable = '0; s2_writedata = '0;
  endtask

  task automatic p_set(input int p, input logic cs, input logic rd,
      input logic wr, input logic [AW-1:0] a, input logic [BW-1:0] be,
      input logic [DW-1:0] d);
    if (p == 1) begin
      s1_chipselect = cs; s1_read = rd; s1_write = wr; s1_address = a;
      s1_byteenable = be; s1_writedata = d;
    end else begin
      s2_chipselect = cs; s2_read = rd; s2_write = wr; s2_address = a;
      s2_byteenable = be; s2_writedata = d;
    end
  endtask

  // One clock cycle with the inputs currently driven; updates the model.
  task automatic tick();
    logic ew, a1, a2;
    #1;
    ew = (clear_left != 0) || reset_req || !clken;
    if (rst_done) begin
      chk("wait_s1", 32'(s1_waitrequest), 32'(ew));
      chk("wait_s2", 32'(s2_waitrequest), 32'(ew));
    end
    a1 = !ew && !reset && s1_chipselect && (s1_read || s1_write);
    a2 = !ew && !reset && s2_chipselect && (s2_read || s2_write);
    @(posedge clk);
    if (reset) begin
      rst_done   = 1;
      clear_left = DEPTH;
      exp1_q.delete(); exp2_q.delete(); t1_q.delete(); t2_q.delete();
    end else if (clken) begin
      ecyc++;
      if (clear_left != 0) begin
        ref_mem[DEPTH - clear_left] = '0;
        clear_left--;
      end else begin
        if (a1 && !s1_write) begin
          exp1_q.push_back(ref_mem[s1_address]); t1_q.push_back(ecyc + LAT - 1);
        end
        if (a2 && !s2_write) begin
          exp2_q.push_back(ref_mem[s2_address]); t2_q.push_back(ecyc + LAT - 1);
        end
        if (!freeze) begin
          if (a2 && s2_write)
            ref_mem[s2_address] = merge(ref_mem[s2_address], s2_writedata, s2_byteenable);
          if (a1 && s1_write)
            ref_mem[s1_address] = merge(ref_mem[s1_address], s1_writedata, s1_byteenable);
        end
      end
    end
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  task automatic mon_port(input int p, input logic v, input logic [DW-1:0] d);
    logic [DW-1:0] e;
    int t, n;
    n = (p == 1) ? exp1_q.size() : exp2_q.size();
    if (v) begin
      if (n == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid_s%0d: got valid=1 data=%h, required no response", p, d);
      end else begin
        if (p == 1) begin e = exp1_q.pop_front(); t = t1_q.pop_front(); last1 = d; end
        else        begin e = exp2_q.pop_front(); t = t2_q.pop_front(); last2 = d; end
        chk($sformatf("rd_data_s%0d", p), d, e);
        chk($sformatf("rd_latency_s%0d", p), 32'(ecyc), 32'(t));
      end
    end else begin
      t = (p == 1) ? ((n > 0) ? t1_q[0] : 0) : ((n > 0) ? t2_q[0] : 0);
      if (n > 0 && t <= ecyc) begin
        checks++; errors++;
        $display("FAIL missing_valid_s%0d: got valid=0, required read response due at cycle %0d", p, t);
        if (p == 1) begin void'(exp1_q.pop_front()); void'(t1_q.pop_front()); end
        else        begin void'(exp2_q.pop_front()); void'(t2_q.pop_front()); end
      end
      chk($sformatf("hold_s%0d", p), d, (p == 1) ? last1 : last2);
    end
  endtask

  initial begin
    bit was_rst, upd;
    forever begin
      @(posedge clk);
      was_rst = reset;
      upd     = clken && !reset;
      @(negedge clk);
      if (was_rst) begin
        chk("rst_valid_s1", 32'(s1_readdatavalid), 32'd0);
        chk("rst_valid_s2", 32'(s2_readdatavalid), 32'd0);
        chk("rst_data_s1", s1_readdata, '0);
        chk("rst_data_s2", s2_readdata, '0);
        last1 = '0; last2 = '0;
      end else if (upd) begin
        mon_port(1, s1_readdatavalid, s1_readdata);
        mon_port(2, s2_readdatavalid, s2_readdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    idle();
    reset = 1; tick(); tick(); reset = 0;
    // partial clear with a clken stall, then reset mid-clear restarts it
    repeat (6) tick();
    clken = 0; repeat (2) tick(); clken = 1;
    reset = 1; tick(); reset = 0;
    repeat (18) tick();

    // every word reads zero after the sweep
    for (int i = 0; i < DEPTH; i++) begin
      idle(); p_set(1, 1, 1, 0, 4'(i), '0, '0); p_set(2, 1, 1, 0, 4'(15 - i), '0, '0);
      tick();
    end

    // byte-enable merge, read from the other port
    idle(); p_set(1, 1, 0, 1, 4'd5, 4'hF, 32'h11223344); tick();
    idle(); p_set(1, 1, 0, 1, 4'd5, 4'b0101, 32'hAABBCCDD); tick();
    idle(); p_set(2, 1, 1, 0, 4'd5, '0, '0); tick();

    // same-address collision: s1 bytes win, other s2 bytes land
    idle(); p_set(1, 1, 0, 1, 4'd3, 4'b0001, 32'h000000FF);
    p_set(2, 1, 0, 1, 4'd3, 4'b0011, 32'h0000AB00); tick();
    idle(); p_set(1, 1, 1, 0, 4'd3, '0, '0); tick();

    // cross-port read-during-write returns old data
    idle(); p_set(1, 1, 0, 1, 4'd7, 4'hF, 32'h5); tick();
    idle(); p_set(1, 1, 0, 1, 4'd7, 4'hF, 32'h9); p_set(2, 1, 1, 0, 4'd7, '0, '0); tick();
    idle(); p_set(2, 1, 1, 0, 4'd7, '0, '0); tick();

    // freeze: write accepted, memory unchanged
    idle(); freeze = 1; p_set(1, 1, 0, 1, 4'd2, 4'hF, 32'h1234); tick();
    idle(); p_set(2, 1, 1, 0, 4'd2, '0, '0); tick();

    // read burst 0..3 with a two-cycle clken drop in the middle
    for (int i = 0; i < 4; i++) begin
      idle(); p_set(2, 1, 0, 1, 4'(i), 4'hF, 32'h100 + 32'(i)); tick();
    end
    idle(); p_set(1, 1, 1, 0, 4'd0, '0, '0); tick();
    p_set(1, 1, 1, 0, 4'd1, '0, '0); tick();
    p_set(1, 1, 1, 0, 4'd2, '0, '0); clken = 0; tick(); tick();
    clken = 1; tick();
    p_set(1, 1, 1, 0, 4'd3, '0, '0); tick();
    idle(); repeat (3) tick();

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      clken     = ($urandom_range(0, 9) != 0);
      reset_req = ($urandom_range(0, 19) == 0);
      freeze    = ($urandom_range(0, 9) == 0);
      p_set(1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 32'($urandom));
      p_set(2, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 32'($urandom));
      tick();
    end

    // read in flight across a reset, then clear again
    idle(); p_set(1, 1, 1, 0, 4'd1, '0, '0); p_set(2, 1, 1, 0, 4'd9, '0, '0); tick();
    idle(); reset = 1; tick(); reset = 0;
    repeat (18) tick();
    idle(); p_set(1, 1, 1, 0, 4'd5, '0, '0); p_set(2, 1, 1, 0, 4'd3, '0, '0); tick();

    idle(); repeat (5) tick();
    chk("drain_s1", 32'(exp1_q.size()), 32'd0);
    chk("drain_s2", 32'(exp2_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
